// File: rtl/led_flow_pkg.sv
// Shared constants and helpers for the LED flow-light controller.
package led_flow_pkg;

    // Pattern modes
    localparam logic [1:0] MODE_ROTL     = 2'd0;
    localparam logic [1:0] MODE_ROTR     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_FILL     = 2'd3;

    // Speed encoding: step period is the base period divided by 2**speed
    typedef enum logic [1:0] {
        SpeedX1 = 2'd0,
        SpeedX2 = 2'd1,
        SpeedX4 = 2'd2,
        SpeedX8 = 2'd3
    } speed_e;

    // Terminal prescaler count for a given base period and speed setting
    function automatic int unsigned calc_limit(input int unsigned base_cycles,
                                               input logic [1:0]  speed);
        return (base_cycles >> speed) - 1;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every (limit + 1) unpaused cycles.
module led_tick_gen #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] limit,
    input  logic             pause,
    input  logic             clear,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // >= rather than == so a lowered limit fires at once instead of waiting for a wrap
    always_comb begin
        tick = ~clear & ~pause & (cnt_q >= limit);
    end

    // Next count: clear wins, pause holds, tick wraps to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (pause) begin
            cnt_d = cnt_q;
        end else if (cnt_q >= limit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_flow_ctrl.sv
// N-LED flow-light controller: four patterns, run-time speed, pause, output polarity.
module led_flow_ctrl #(
    parameter int unsigned LED_NUM    = 8,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned STEP_MS    = 500,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    input  logic               pause,
    output logic [LED_NUM-1:0] led_on,
    output logic               step_pulse
);

    import led_flow_pkg::*;

    localparam int unsigned BASE_CYCLES = CLK_HZ / 1000 * STEP_MS;
    localparam int unsigned CNT_W       = $clog2(BASE_CYCLES);

    localparam logic [LED_NUM-1:0] PAT_INIT = {{(LED_NUM-1){1'b0}}, 1'b1};

    logic [LED_NUM-1:0] pat_q, pat_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   limit;
    logic               tick;
    logic               mode_chg;

    assign limit    = CNT_W'(calc_limit(BASE_CYCLES, speed));
    assign mode_chg = (mode != mode_q);

    led_tick_gen #(
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .limit (limit),
        .pause (pause),
        .clear (mode_chg),
        .tick  (tick)
    );

    // State register: pattern, direction, latched mode and step strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= PAT_INIT;
            dir_q  <= 1'b0;
            mode_q <= mode;
            step_q <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            mode_q <= mode;
            step_q <= step_d;
        end
    end

    // Next pattern: a mode change restarts the pattern and suppresses the coincident step
    always_comb begin
        pat_d  = pat_q;
        dir_d  = dir_q;
        step_d = tick & ~mode_chg;
        if (mode_chg) begin
            pat_d = PAT_INIT;
            dir_d = 1'b0;
        end else if (tick) begin
            case (mode_q)
                MODE_ROTL: pat_d = {pat_q[LED_NUM-2:0], pat_q[LED_NUM-1]};
                MODE_ROTR: pat_d = {pat_q[0], pat_q[LED_NUM-1:1]};
                MODE_PINGPONG: begin
                    // Direction flips on arrival at an end so ends are not repeated
                    if (!dir_q) begin
                        pat_d = pat_q << 1;
                        if (pat_q[LED_NUM-2]) dir_d = 1'b1;
                    end else begin
                        pat_d = pat_q >> 1;
                        if (pat_q[1]) dir_d = 1'b0;
                    end
                end
                MODE_FILL: begin
                    if (&pat_q) pat_d = PAT_INIT;
                    else        pat_d = {pat_q[LED_NUM-2:0], 1'b1};
                end
                default: pat_d = PAT_INIT;
            endcase
        end
    end

    // Outputs straight from registers; polarity applied without an extra stage
    always_comb begin
        led_on     = (ACTIVE_LOW != 0) ? ~pat_q : pat_q;
        step_pulse = step_q;
    end

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Directed bench for led_flow_ctrl with BASE_CYCLES = 16 and 8 active-low LEDs.
module tb_led_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [7:0] led_on;
    logic       step_pulse;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] speed;
        logic [7:0] led;
        int         gap;
    } vec_t;

    vec_t vecs[$];

    led_flow_ctrl #(
        .LED_NUM    (8),
        .CLK_HZ     (1000),
        .STEP_MS    (16),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .speed      (speed),
        .pause      (pause),
        .led_on     (led_on),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Counts negedges until step_pulse is seen; n == budget means it never came
    task automatic wait_step(input int budget, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(negedge clk);
            n++;
            if (step_pulse) seen = 1'b1;
        end
    endtask

    task automatic add(input logic [1:0] m, input logic [1:0] s, input logic [7:0] l,
                       input int g);
        vec_t v;
        v.mode  = m;
        v.speed = s;
        v.led   = l;
        v.gap   = g;
        vecs.push_back(v);
    endtask

    initial begin
        int         n;
        logic [7:0] one;
        int         pp_idx[16];
        logic [7:0] fill_led[9];

        pp_idx   = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        fill_led = '{8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'hFE, 8'hFC};
        one      = 8'h01;

        // Rotate left, speed 0: FD, FB, ..., 7F, FE every 16 cycles
        for (int i = 0; i < 8; i++) add(2'd0, 2'd0, ~(one << ((i + 1) % 8)), 16);
        // Ping-pong, speed 3: mode change costs one extra cycle before the first step
        for (int i = 0; i < 16; i++) add(2'd2, 2'd3, ~(one << pp_idx[i]), (i == 0) ? 3 : 2);
        // Fill, speed 2
        for (int i = 0; i < 9; i++) add(2'd3, 2'd2, fill_led[i], (i == 0) ? 5 : 4);

        rst_n = 1'b0;
        mode  = 2'd0;
        speed = 2'd0;
        pause = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", led_on, 8'hFE);
        check("reset_step", step_pulse, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            mode  = vecs[i].mode;
            speed = vecs[i].speed;
            wait_step(100, n);
            check($sformatf("vec%0d_gap", i), n, vecs[i].gap);
            check($sformatf("vec%0d_led", i), led_on, vecs[i].led);
        end

        // Pause at cnt = 5 for 20 cycles, resume takes 15 - 5 + 1 cycles
        mode  = 2'd0;
        speed = 2'd0;
        wait_step(100, n);
        check("pause_pre_gap", n, 17);
        check("pause_pre_led", led_on, 8'hFD);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("paused_step", step_pulse, 0);
            check("paused_led", led_on, 8'hFD);
        end
        pause = 1'b0;
        wait_step(100, n);
        check("resume_gap", n, 11);
        check("resume_led", led_on, 8'hFB);

        // Rotate right, then switch to fill on the cycle the tick would fire
        mode = 2'd1;
        wait_step(100, n);
        check("rotr_gap", n, 17);
        check("rotr_led", led_on, 8'h7F);
        repeat (15) @(negedge clk);
        mode = 2'd3;
        @(negedge clk);
        check("switch_led", led_on, 8'hFE);
        check("switch_step", step_pulse, 0);
        wait_step(100, n);
        check("switch_gap", n, 16);
        check("switch_next_led", led_on, 8'hFC);

        // Ping-pong moving down, then asynchronous reset mid-period
        mode  = 2'd2;
        speed = 2'd3;
        for (int i = 0; i < 8; i++) wait_step(100, n);
        check("pp_down_led", led_on, 8'hBF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", led_on, 8'hFE);
        check("async_rst_step", step_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_step(100, n);
        check("post_rst_gap", n, 2);
        check("post_rst_led", led_on, 8'hFD);
        wait_step(100, n);
        check("post_rst_led2", led_on, 8'hFB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_flow_ctrl.md
# led_flow_ctrl

Parametrised LED flow-light controller for the board LED bank. It generalises the fixed 4-LED, 1-step-per-second rotating light to N LEDs with four selectable patterns, run-time speed selection, pause and selectable output polarity. It sits between the board clock/reset and the LED pins, and exports a step strobe for other display logic.

## Interface
- `LED_NUM`, default 8: number of LEDs; legal range is 2..32.
- `CLK_HZ`, default 50_000_000: clock frequency in Hz.
- `STEP_MS`, default 500: step period at speed 0, in ms. `BASE_CYCLES = CLK_HZ/1000*STEP_MS` must be divisible by 8 and at least 8.
- `ACTIVE_LOW`, default 1: when 1, an LED is lit by driving 0.

- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `mode`, in, 2: 0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = fill bar.
- `speed`, in, 2: step period is `BASE_CYCLES >> speed` cycles.
- `pause`, in, 1: freezes the pattern and the prescaler.
- `led_on`, out, `LED_NUM`: LED drive.
- `step_pulse`, out, 1: one-cycle strobe on each pattern update.

## Operation
- Internal pattern `pat[LED_NUM-1:0]` is positive logic (1 = lit). `led_on = ACTIVE_LOW ? ~pat : pat`, registered with no extra stage.
- Internal state: `pat`, prescaler `cnt` (width `$clog2(BASE_CYCLES)`), direction bit `dir` (0 = up), registered copy `mode_q`.
- Reset values:
  - `pat = 1` (bit 0 lit), `cnt = 0`, `dir = 0`, `mode_q = mode`, `step_pulse = 0`.
  - `led_on` = `{LED_NUM{1}}` with bit 0 = 0 when `ACTIVE_LOW`; otherwise only bit 0 = 1.
- Prescaler:
  - `limit = (BASE_CYCLES >> speed) - 1`.
  - The tick fires when `cnt >= limit` and `pause == 0`. On a tick, `cnt` goes to 0.
  - Otherwise `cnt` increments when not paused and holds when paused.
- Using `>=` means that raising `speed` mid-count fires the tick on the next cycle; it does not wait for a wrap.
- On a tick, `pat` advances according to `mode_q`:
  - **Rotate left:** `pat <= {pat[N-2:0], pat[N-1]}`.
  - **Rotate right:** `pat <= {pat[0], pat[N-1:1]}`.
  - **Ping-pong:** one lit bit moves up while `dir = 0`.
    - On reaching bit N-1, `dir` flips and the next step moves down.
    - At bit 0, `dir` flips back to up.
    - The end positions are never repeated: the sequence is 0,1,…,N-1,N-2,…,1,0,1,…
  - **Fill:** `pat <= {pat[N-2:0], 1'b1}` while `pat != all-ones`. When `pat` is all ones, it returns to `pat <= 1`. The sequence is 1, 3, 7, …, all-ones, 1.
- Mode change: when `mode != mode_q`, on that clock edge:
  - `mode_q <= mode`, `pat <= 1`, `dir <= 0`, `cnt <= 0`.
  - No step occurs and there is no `step_pulse`.
  - This has priority over a coincident tick and applies even while `pause = 1`.
- `step_pulse` is registered: it is 1 in exactly the cycle following a tick edge, which is the cycle in which the new `pat` is visible.
- `pause` asserted: `pat`, `cnt` and `dir` hold, and `step_pulse` is 0. On deassertion, counting resumes from the held `cnt`.
- Reset asserted mid-operation forces all reset values immediately, asynchronously.

## Timing
- Step period is `(BASE_CYCLES >> speed)` cycles, measured between consecutive `step_pulse` highs while unpaused.
- After reset release, the first step occurs `BASE_CYCLES >> speed` cycles after the first active edge.
- After a mode change, the first step of the new mode occurs a full period later.
- Latency from `pause` deassertion to the next step is `limit - cnt_held + 1` cycles.
- `mode`, `speed` and `pause` are synchronous inputs. Debounce and synchronisation are done outside this block.

## Structure
- Package `led_flow_pkg` holds:
  - mode constants `MODE_ROTL = 2'd0`, `MODE_ROTR = 2'd1`, `MODE_PINGPONG = 2'd2`, `MODE_FILL = 2'd3`;
  - the speed encoding;
  - a function computing `limit` from `BASE_CYCLES` and `speed`.
- One sub-module, `led_tick_gen`, contains the prescaler:
  - inputs: `clk`, `rst_n`, `limit`, `pause`, `clear`;
  - output: a one-cycle `tick`.
- The top level holds the pattern register, `dir`, `mode_q` and the output polarity logic.

## Test plan
Bench parameters: `LED_NUM = 8`, `CLK_HZ = 1000`, `STEP_MS = 16`, `ACTIVE_LOW = 1`, so `BASE_CYCLES = 16`.

- **Reset then rotate left, speed 0** → `led_on` is 8'hFE in reset. Then 8'hFD, 8'hFB, …, 8'h7F, 8'hFE, one step every 16 cycles, with `step_pulse` high exactly one cycle per step.
- **Ping-pong, speed 3 (2-cycle period), 16 steps** → lit index goes 1,2,…,7,6,…,0,1; 8'h7F is never repeated consecutively.
- **Fill, speed 2** → `pat` goes 01, 03, 07, …, FF, 01. `led_on` goes FE, FC, …, 00, FE, with a 4-cycle period.
- **Pause for 20 cycles at `cnt = 5`** → no change and no `step_pulse` while paused. The first step comes 11 cycles after release.
- **Mode switch from rotate right to fill on a tick cycle** → `pat` becomes 01 with no `step_pulse`. The next step, to 03, arrives 16 cycles later.
- **`rst_n` pulsed low mid-period in ping-pong moving down** → `led_on` is 8'hFE immediately and `dir` is up. After release, the next step gives 8'hFD.
